// File: rtl/tag_lookup_pkg.sv
// tag_lookup_pkg: op encoding, default geometry and PLRU node count for tag_way_lookup
package tag_lookup_pkg;
  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_ALLOC  = 2'd1,
    OP_INVAL  = 2'd2
  } op_e;
  localparam int DEF_WAYS  = 8;
  localparam int DEF_SETS  = 16;
  localparam int DEF_TAG_W = 12;
  function automatic int plru_nodes(input int ways);
    return ways - 1;
  endfunction
endpackage

// File: rtl/tag_way_lookup_plru_tree.sv
// plru_tree: heap-indexed tree PLRU, combinational victim walk and touch update
module plru_tree #(
  parameter int WAYS = 8,
  localparam int LW = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] state,
  input  logic [LW-1:0]   touch_way,
  output logic [LW-1:0]   victim,
  output logic [WAYS-2:0] next_state
);
  logic [LW-1:0] n, m;
  always_comb begin
    victim = '0;
    next_state = state;
    n = '0;
    m = '0;
    for (int l = 0; l < LW; l++) begin
      victim[LW-1-l] = state[n];
      n = LW'(2 * n + 1 + state[n]);
      next_state[m] = !touch_way[LW-1-l];
      m = LW'(2 * m + 1 + touch_way[LW-1-l]);
    end
  end
endmodule

// File: rtl/tag_way_lookup.sv
// tag_way_lookup: per-set tag store with hit/victim select and registered response; TAG_LOOKUP_PERF_EN adds hit/miss counters
module tag_way_lookup
  import tag_lookup_pkg::*;
#(
  parameter int WAYS  = DEF_WAYS,
  parameter int SETS  = DEF_SETS,
  parameter int TAG_W = DEF_TAG_W,
  localparam int IW = $clog2(SETS),
  localparam int LW = $clog2(WAYS),
  localparam int PN = plru_nodes(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IW-1:0]    req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [LW-1:0]    rsp_way,
  output logic             rsp_evict_valid,
  output logic [TAG_W-1:0] rsp_evict_tag
`ifdef TAG_LOOKUP_PERF_EN
  ,
  output logic [31:0]      perf_hits,
  output logic [31:0]      perf_misses
`endif
);
  logic [WAYS-1:0]  valid_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [PN-1:0]    plru_q  [SETS];
  logic [WAYS-1:0]  vset, match;
  logic [LW-1:0]    hit_way, inv_way, victim, alloc_way, touch_way, way_d;
  logic [PN-1:0]    plru_next;
  logic             hit, any_inv, acc, is_alloc, is_inval, alloc_miss, inval_hit, touch, ev_d;
  always_comb begin
    vset = valid_q[req_index];
    match = '0;
    hit_way = '0;
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      match[i] = vset[i] && (tag_q[req_index][i] == req_tag);
      hit_way = match[i] ? LW'(i) : hit_way;
      inv_way = !vset[i] ? LW'(i) : inv_way;
    end
  end
  assign hit        = |match;
  assign any_inv    = ~&vset;
  assign req_ready  = !rsp_valid || rsp_ready;
  assign acc        = req_valid && req_ready;
  assign is_alloc   = req_op == OP_ALLOC;
  assign is_inval   = req_op == OP_INVAL;
  assign alloc_miss = is_alloc && !hit;
  assign inval_hit  = is_inval && hit;
  assign touch      = (hit && !is_inval) || alloc_miss;
  assign alloc_way  = any_inv ? inv_way : victim;
  assign touch_way  = hit ? hit_way : alloc_way;
  assign way_d      = hit ? hit_way : (alloc_miss ? alloc_way : '0);
  assign ev_d       = alloc_miss && !any_inv;
  plru_tree #(.WAYS(WAYS)) u_plru (
    .state(plru_q[req_index]),
    .touch_way(touch_way),
    .victim(victim),
    .next_state(plru_next)
  );
  always_ff @(posedge clk)
    if (acc && alloc_miss) tag_q[req_index][alloc_way] <= req_tag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s] <= '0;
      end
      rsp_valid <= 1'b0;
      rsp_hit <= 1'b0;
      rsp_way <= '0;
      rsp_evict_valid <= 1'b0;
      rsp_evict_tag <= '0;
    end else if (acc) begin
      if (alloc_miss) valid_q[req_index][alloc_way] <= 1'b1;
      if (inval_hit) valid_q[req_index][hit_way] <= 1'b0;
      if (touch) plru_q[req_index] <= plru_next;
      rsp_valid <= 1'b1;
      rsp_hit <= hit;
      rsp_way <= way_d;
      rsp_evict_valid <= ev_d;
      rsp_evict_tag <= ev_d ? tag_q[req_index][alloc_way] : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
`ifdef TAG_LOOKUP_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hits <= '0;
      perf_misses <= '0;
    end else if (acc && !is_inval) begin
      if (hit && !(&perf_hits)) perf_hits <= perf_hits + 32'd1;
      if (!hit && !(&perf_misses)) perf_misses <= perf_misses + 32'd1;
    end
  end
`endif
  a_single_match: assert property (@(posedge clk) disable iff (!rst_n) req_valid |-> $onehot0(match));
endmodule

// File: tb/tb_tag_way_lookup.sv
// tb_tag_way_lookup: directed scoreboard bench for tag_way_lookup
module tb_tag_way_lookup;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [3:0]  req_index = 4'd0;
  logic [11:0] req_tag = 12'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_hit;
  logic [2:0]  rsp_way;
  logic        rsp_evict_valid;
  logic [11:0] rsp_evict_tag;
`ifdef TAG_LOOKUP_PERF_EN
  logic [31:0] perf_hits, perf_misses;
`endif
  typedef struct packed {
    logic        hit;
    logic [2:0]  way;
    logic        ev;
    logic [11:0] et;
  } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  localparam logic [1:0] LK = 2'd0, AL = 2'd1, IN = 2'd2;
  tag_way_lookup dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_index(req_index),
    .req_tag(req_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_hit(rsp_hit),
    .rsp_way(rsp_way),
    .rsp_evict_valid(rsp_evict_valid),
    .rsp_evict_tag(rsp_evict_tag)
`ifdef TAG_LOOKUP_PERF_EN
    ,
    .perf_hits(perf_hits),
    .perf_misses(perf_misses)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got hit=%0d way=%0d, no response expected", rsp_hit, rsp_way);
      end else begin
        e = exp_q.pop_front();
        if (rsp_hit !== e.hit || rsp_way !== e.way || rsp_evict_valid !== e.ev || (e.ev && rsp_evict_tag !== e.et)) begin
          errors++;
          $display("FAIL rsp: got hit=%0d way=%0d ev=%0d etag=%h, want hit=%0d way=%0d ev=%0d etag=%h",
                   rsp_hit, rsp_way, rsp_evict_valid, rsp_evict_tag, e.hit, e.way, e.ev, e.et);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [3:0] idx, input logic [11:0] tag,
                       input logic h, input logic [2:0] w, input logic ev, input logic [11:0] et);
    int cnt;
    req_valid = 1'b1;
    req_op = op;
    req_index = idx;
    req_tag = tag;
    cnt = 0;
    @(negedge clk);
    while (!req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%0d, want 1", req_ready);
    end else begin
      exp_q.push_back('{hit: h, way: w, ev: ev, et: et});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask
  task automatic drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_rsp_way", 32'(rsp_way), 0);
    chk("reset_rsp_evict", 32'({rsp_hit, rsp_evict_valid, rsp_evict_tag}), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(LK, 4'd3, 12'h123, 0, 0, 0, 0);
    issue(AL, 4'd3, 12'h123, 0, 0, 0, 0);
    issue(LK, 4'd3, 12'h123, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) issue(AL, 4'd5, 12'(12'h10 + i), 0, 3'(i), 0, 0);
    issue(AL, 4'd5, 12'h020, 0, 0, 1, 12'h010);
    issue(LK, 4'd5, 12'h010, 0, 0, 0, 0);
    issue(AL, 4'd5, 12'h021, 0, 4, 1, 12'h014);
    issue(AL, 4'd5, 12'h022, 0, 2, 1, 12'h012);
    issue(LK, 4'd5, 12'h017, 1, 7, 0, 0);
    issue(AL, 4'd5, 12'h017, 1, 7, 0, 0);
    issue(IN, 4'd3, 12'h123, 1, 0, 0, 0);
    issue(LK, 4'd3, 12'h123, 0, 0, 0, 0);
    issue(IN, 4'd3, 12'h999, 0, 0, 0, 0);
    issue(IN, 4'd5, 12'h021, 1, 4, 0, 0);
    issue(AL, 4'd5, 12'h030, 0, 4, 0, 0);
    issue(LK, 4'd5, 12'h030, 1, 4, 0, 0);
    issue(2'd3, 4'd5, 12'h030, 1, 4, 0, 0);
    drain();
    rsp_ready = 1'b0;
    issue(LK, 4'd5, 12'h022, 1, 2, 0, 0);
    fork
      issue(LK, 4'd5, 12'h015, 1, 5, 0, 0);
    join_none
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 0);
      chk("stall_rsp_valid", 32'(rsp_valid), 1);
      chk("stall_rsp_fields", 32'({rsp_hit, rsp_way, rsp_evict_valid}), 32'({1'b1, 3'd2, 1'b0}));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait fork;
    drain();
    rsp_ready = 1'b0;
    issue(LK, 4'd5, 12'h022, 1, 2, 0, 0);
    void'(exp_q.pop_back());
    #2;
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_rsp_valid", 32'(rsp_valid), 0);
    chk("async_reset_rsp_fields", 32'({rsp_hit, rsp_way}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    issue(LK, 4'd5, 12'h022, 0, 0, 0, 0);
    issue(LK, 4'd5, 12'h015, 0, 0, 0, 0);
    issue(AL, 4'd5, 12'h040, 0, 0, 0, 0);
    issue(AL, 4'd5, 12'h041, 0, 1, 0, 0);
    drain();
    repeat (2) @(negedge clk);
    chk("idle_rsp_valid", 32'(rsp_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
